// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file sizing and the dump sequencer states.
// Imported by regfile_dump and by the register file itself.
package regfile_pkg;

  localparam int RF_WIDTH  = 32;
  localparam int RF_ADDR_W = 5;
  localparam int REG_COUNT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } dump_state_e;

endpackage

// File: rtl/regfile_dump.sv
// regfile_dump: streams a wrapping range of register-file words over valid/ready.
// Optional DumpParity output when REGFILE_DUMP_PARITY_EN is defined.
module regfile_dump
  import regfile_pkg::*;
#(
  parameter int WIDTH  = RF_WIDTH,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic [ADDR_W-1:0] StartAddr,
  input  logic [ADDR_W-1:0] Count,
  output logic [ADDR_W-1:0] ReadRegister,
  input  logic [WIDTH-1:0]  ReadData,
  output logic [WIDTH-1:0]  DumpData,
  output logic [ADDR_W-1:0] DumpAddr,
  output logic              DumpLast,
  output logic              DumpValid,
  input  logic              DumpReady,
  output logic              Busy,
  output logic              Done
`ifdef REGFILE_DUMP_PARITY_EN
  ,
  output logic              DumpParity
`endif
);

  localparam logic [ADDR_W:0] REM_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] REM_FULL = {1'b1, {ADDR_W{1'b0}}};

  dump_state_e       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W:0]   rem_q;
  logic [ADDR_W:0]   rem_d;
  logic [ADDR_W:0]   rem_init;
  logic [WIDTH-1:0]  data_q;
  logic [ADDR_W-1:0] daddr_q;
  logic              last_q;
  logic              valid_q;
  logic              done_q;
  logic              rem_is_one;
`ifdef REGFILE_DUMP_PARITY_EN
  logic              parity_q;
`endif

  // Next address/count values and the Count==0 -> full-range decode
  always_comb begin
    addr_d     = addr_q + 1'b1;
    rem_d      = rem_q - REM_ONE;
    rem_init   = (Count == '0) ? REM_FULL : {1'b0, Count};
    rem_is_one = (rem_q == REM_ONE);
  end

  // Sequencer FSM with registered stream outputs
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      data_q   <= '0;
      daddr_q  <= '0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef REGFILE_DUMP_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (Start) begin
            addr_q  <= StartAddr;
            rem_q   <= rem_init;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          data_q   <= ReadData;
          daddr_q  <= addr_q;
          last_q   <= rem_is_one;
          valid_q  <= 1'b1;
`ifdef REGFILE_DUMP_PARITY_EN
          parity_q <= ^ReadData;
`endif
          state_q  <= SEND;
        end
        SEND: begin
          if (valid_q && DumpReady) begin
            valid_q <= 1'b0;
            if (rem_is_one) begin
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              addr_q  <= addr_d;
              rem_q   <= rem_d;
              state_q <= FETCH;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ReadRegister = addr_q;
  assign DumpData     = data_q;
  assign DumpAddr     = daddr_q;
  assign DumpLast     = last_q;
  assign DumpValid    = valid_q;
  assign Done         = done_q;
  assign Busy         = (state_q != IDLE);
`ifdef REGFILE_DUMP_PARITY_EN
  assign DumpParity   = parity_q;
`endif

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Read-side sequencer for the 32x32 MIPS register file: walks a contiguous, wrapping range of register addresses on one read port and streams each word out over a valid/ready interface.
- Used by the debug/trace path and the context-save path to snapshot architectural state without stalling the write port.
- Drives ReadRegister only; never touches WriteData, WriteRegister or RegWrite.

Parameters:
- WIDTH, 32, data word width; matches the register file width.
- ADDR_W, 5, register address width; the range covers 2^ADDR_W registers.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst_n  input  1  reset; asynchronous, active-low.
- Start  input  1  request a dump; sampled only in IDLE.
- StartAddr  input  ADDR_W  first register to read.
- Count  input  ADDR_W  number of words; 0 means 2^ADDR_W (32).
- ReadRegister  output  ADDR_W  address to the register file read port.
- ReadData  input  WIDTH  asynchronous read data from the register file.
- DumpData  output  WIDTH  streamed register contents.
- DumpAddr  output  ADDR_W  register index of DumpData.
- DumpLast  output  1  marks the final word of the dump.
- DumpValid  output  1  stream valid.
- DumpReady  input  1  stream ready from the consumer.
- Busy  output  1  high whenever state is not IDLE.
- Done  output  1  one-cycle pulse after the last handshake.

Behaviour:
- Reset (async, Rst_n=0):
  - state=IDLE.
  - DumpValid=0, DumpLast=0, Done=0, Busy=0.
  - DumpData=0, DumpAddr=0, internal address=0, remaining count=0.
  - ReadRegister=0.
- Reset asserted mid-dump aborts immediately. The partial word is dropped and no Done pulse is generated.
- State IDLE:
  - Start=1 at an edge latches addr<=StartAddr and rem<=(Count==0 ? 32 : Count), then moves to FETCH.
  - Start=0 keeps the block in IDLE.
- State FETCH (one cycle):
  - ReadRegister=addr, driven combinationally from the register.
  - At the edge: DumpData<=ReadData, DumpAddr<=addr, DumpLast<=(rem==1), DumpValid<=1, then move to SEND.
- State SEND:
  - DumpData, DumpAddr and DumpLast are held stable while DumpValid=1 and DumpReady=0.
  - On a handshake (DumpValid & DumpReady at an edge) with rem==1: DumpValid<=0, DumpLast<=0, Done<=1 for one cycle, move to IDLE.
  - On a handshake with rem>1: addr<=addr+1 modulo 2^ADDR_W (31 wraps to 0), rem<=rem-1, DumpValid<=0, move to FETCH.
- ReadRegister holds addr in every state.
- Timing:
  - Start accepted at edge N gives the first DumpValid after edge N+1.
  - Each following word appears 2 cycles after the previous handshake.
  - Peak throughput is 1 word per 2 cycles.
- Write coherence:
  - Each word is a snapshot taken at its FETCH edge.
  - A register-file write to the same address in that same cycle is not visible, because the write lands at the same edge.
  - Later writes do not alter a captured word.
- Start while Busy is ignored; no queuing.
- DumpValid never deasserts without a handshake, except on reset.
- Register 0 is dumped like any other; the register file supplies its value.

Optional Feature:
- Macro REGFILE_DUMP_PARITY_EN.
- Defined:
  - Adds output DumpParity (1 bit), the even parity (XOR reduction) of the captured ReadData.
  - It is registered at the FETCH edge with DumpData, held with it, and reset to 0.
- Undefined: the DumpParity port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package regfile_pkg:
  - state encoding IDLE=2'd0, FETCH=2'd1, SEND=2'd2;
  - REG_COUNT=32;
  - the shared WIDTH/ADDR_W defaults, also used by the register file.
- No sub-module. The FSM, address/count registers and output holding register sit in one module, about 150 lines.

Test Plan:
- Basic dump: reset; preload r3=0xA5A5_0003, r4=0x0000_0004, r5=0xFFFF_FFFF; StartAddr=3, Count=3, DumpReady=1 -> words (3,0xA5A50003), (4,0x4), (5,0xFFFFFFFF) with DumpLast only on r5; Done pulses once; Busy falls with Done; first DumpValid 2 cycles after Start.
- Wrap plus Count=0: StartAddr=30, Count=0, DumpReady=1 -> 32 words in address order 30, 31, 0, 1, ... 29; r0 reads 0; DumpLast only on address 29.
- Backpressure: StartAddr=7, Count=2; hold DumpReady=0 for 5 cycles after the first valid -> DumpData/DumpAddr stay at r7 and DumpValid stays 1; release -> r8 follows and Done pulses.
- Write coherence: during FETCH of r9 (old value 0x11), write r9=0x22 in the same cycle -> stream carries 0x11. A second dump of r9 -> 0x22.
- Start while busy plus reset abort: assert Start with StartAddr=0 mid-dump -> ignored, sequence unchanged. Then pull Rst_n low mid-SEND -> DumpValid=0, Busy=0 and Done=0 immediately, asynchronously; after release, state is IDLE.
- With REGFILE_DUMP_PARITY_EN: dump r5=0xFFFF_FFFF and r3=0x0000_0007 -> DumpParity 0 and 1 respectively.
